// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: mode encoding and shift direction.
// No logic, so no latency.
// No handshake, so no backpressure.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_HOLD  = 2'b00,
        SH_SHIFT = 2'b01,
        SH_LOAD  = 2'b10,
        SH_ROT   = 2'b11
    } shift_mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Width of a counter that counts 0..w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Bundle of the control, data and status signals of the universal shift register.
// Wires only, so no latency.
// No backpressure; the host sees the register's outputs directly.
interface universal_shift_reg_if #(
    parameter int WIDTH = 4
);
    import shift_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    logic              en;
    shift_mode_e       mode;
    logic              dir;
    logic              sin;
    logic [WIDTH-1:0]  pin;
    logic [WIDTH-1:0]  q;
    logic              sout;
    logic [CW-1:0]     bit_cnt;
    logic              frame_done;

    modport master (
        output en, mode, dir, sin, pin,
        input  q, sout, bit_cnt, frame_done
    );

    modport slave (
        input  en, mode, dir, sin, pin,
        output q, sout, bit_cnt, frame_done
    );

endinterface

// File: rtl/shift_bit_counter.sv
// Counts shifts modulo WIDTH and strobes frame_done on the WIDTH-th shift.
// frame_done is registered: it shows in the cycle after the wrapping edge.
// No backpressure; inc/clr are sampled on every edge.
module shift_bit_counter
    import shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] bit_cnt,
    output logic          frame_done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          frame_done_q, frame_done_d;

    // clr wins over inc so a load landing on the last count never strobes.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        if (clr) begin
            bit_cnt_d = '0;
        end else if (inc) begin
            if (bit_cnt_q == LAST) begin
                bit_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bit_cnt    = bit_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift, parallel load or rotate, either direction.
// q updates on the clock edge; sout is combinational from q; frame_done lags one cycle.
// No backpressure; en=0 freezes all state.
module universal_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic                  clk,
    input logic                  rst,
    universal_shift_reg_if.slave bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_in;
    logic             shifting;
    logic             loading;
    logic             out_bit;

    // The bit leaving the register is also the serial output, so rotate reuses it.
    assign out_bit = (bus.dir == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];

    always_comb begin
        shifting = bus.en && ((bus.mode == SH_SHIFT) || (bus.mode == SH_ROT));
        loading  = bus.en && (bus.mode == SH_LOAD);
        ser_in   = (bus.mode == SH_ROT) ? out_bit : bus.sin;
        q_d      = q_q;
        if (loading) begin
            q_d = bus.pin;
        end else if (shifting) begin
            if (bus.dir == DIR_LEFT) begin
                q_d = {q_q[WIDTH-2:0], ser_in};
            end else begin
                q_d = {ser_in, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = out_bit;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (shifting),
        .clr        (loading),
        .bit_cnt    (bus.bit_cnt),
        .frame_done (bus.frame_done)
    );

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: WIDTH=4 and WIDTH=5 instances checked against a shift-count model.
module tb_universal_shift_reg;
    import shift_pkg::*;

    localparam logic [4:0] RST5 = 5'b10110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    universal_shift_reg_if #(.WIDTH(4)) if4 ();
    universal_shift_reg_if #(.WIDTH(5)) if5 ();

    universal_shift_reg #(.WIDTH(4), .RST_VAL(4'b0000)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    universal_shift_reg #(.WIDTH(5), .RST_VAL(RST5))    dut5 (.clk(clk), .rst(rst), .bus(if5));

    logic        en_v  [2];
    shift_mode_e mode_v[2];
    logic        dir_v [2];
    logic        sin_v [2];
    logic [63:0] pin_v [2];

    assign if4.en = en_v[0];  assign if4.mode = mode_v[0];  assign if4.dir = dir_v[0];
    assign if4.sin = sin_v[0]; assign if4.pin = pin_v[0][3:0];
    assign if5.en = en_v[1];  assign if5.mode = mode_v[1];  assign if5.dir = dir_v[1];
    assign if5.sin = sin_v[1]; assign if5.pin = pin_v[1][4:0];

    logic [63:0] aq[2], acnt[2];
    logic        asout[2], afd[2];
    assign aq[0] = {60'd0, if4.q};       assign aq[1] = {59'd0, if5.q};
    assign acnt[0] = {62'd0, if4.bit_cnt}; assign acnt[1] = {61'd0, if5.bit_cnt};
    assign asout[0] = if4.sout;  assign asout[1] = if5.sout;
    assign afd[0] = if4.frame_done; assign afd[1] = if5.frame_done;

    // Model: register value as an integer, shift count since load/reset, pending strobe.
    logic [63:0] mq[2];
    int          mcnt[2];
    logic        mfd[2];

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_on = 1'b0;

    function automatic int wid(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic logic [63:0] rstval(input int i);
        return (i == 0) ? 64'd0 : {59'd0, RST5};
    endfunction

    function automatic logic msout(input int i);
        return dir_v[i] ? mq[i][wid(i)-1] : mq[i][0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic mreset(input int i);
        mq[i] = rstval(i); mcnt[i] = 0; mfd[i] = 1'b0;
    endtask

    task automatic mstep(input int i);
        int w;
        logic [63:0] mask;
        logic b;
        w = wid(i);
        mask = (64'd1 << w) - 64'd1;
        if (!rst) begin mreset(i); return; end
        mfd[i] = 1'b0;
        if (!en_v[i]) return;
        case (mode_v[i])
            SH_LOAD: begin mq[i] = pin_v[i] & mask; mcnt[i] = 0; end
            SH_SHIFT, SH_ROT: begin
                b = (mode_v[i] == SH_ROT) ? msout(i) : sin_v[i];
                if (dir_v[i]) mq[i] = ((mq[i] << 1) | {63'd0, b}) & mask;
                else          mq[i] = (mq[i] >> 1) | ({63'd0, b} << (w - 1));
                mcnt[i]++;
                if (mcnt[i] == w) begin mcnt[i] = 0; mfd[i] = 1'b1; end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        mstep(0); mstep(1);
        #1;
    endtask

    task automatic drive(input int i, input logic e, input shift_mode_e m, input logic d,
                         input logic s, input logic [63:0] p);
        en_v[i] = e; mode_v[i] = m; dir_v[i] = d; sin_v[i] = s; pin_v[i] = p;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("q[w%0d]", wid(i)), aq[i], mq[i]);
                chk($sformatf("bit_cnt[w%0d]", wid(i)), acnt[i], 64'(mcnt[i]));
                chk($sformatf("sout[w%0d]", wid(i)), {63'd0, asout[i]}, {63'd0, msout(i)});
                chk($sformatf("frame_done[w%0d]", wid(i)), {63'd0, afd[i]}, {63'd0, mfd[i]});
            end
        end
    end

    logic [3:0] siso_sin, siso_q[4];
    logic [3:0] rot_q[4];
    logic [3:0] piso_sout;

    initial begin
        siso_sin = 4'b1101;   // applied LSB first: 1,0,1,1
        siso_q[0] = 4'b1000; siso_q[1] = 4'b0100; siso_q[2] = 4'b1010; siso_q[3] = 4'b1101;
        rot_q[0] = 4'b0001; rot_q[1] = 4'b0010; rot_q[2] = 4'b0100; rot_q[3] = 4'b1000;
        piso_sout = 4'b1001;  // read LSB first: 1,0,0,1
        for (int i = 0; i < 2; i++) drive(i, 1'b0, SH_HOLD, DIR_RIGHT, 1'b0, 64'd0);

        // Asynchronous reset, no clock edge yet.
        #1 rst = 1'b0;
        mreset(0); mreset(1);
        #1;
        chk("rst_q4", aq[0], 64'h0);
        chk("rst_q5", aq[1], 64'h16);
        chk("rst_cnt4", acnt[0], 64'h0);
        chk("rst_fd4", {63'd0, afd[0]}, 64'h0);
        tick(); tick();
        rst = 1'b1;
        cmp_on = 1'b1;

        // SISO right shift.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, SH_SHIFT, DIR_RIGHT, siso_sin[k], 64'd0);
            tick();
            chk($sformatf("siso_q%0d", k), aq[0], {60'd0, siso_q[k]});
            chk($sformatf("siso_fd%0d", k), {63'd0, afd[0]}, {63'd0, (k == 3)});
        end
        chk("siso_cnt_wrap", acnt[0], 64'h0);
        drive(0, 1'b1, SH_HOLD, DIR_RIGHT, 1'b0, 64'd0);
        tick();
        chk("siso_fd_one_cycle", {63'd0, afd[0]}, 64'h0);

        // PISO.
        drive(0, 1'b1, SH_LOAD, DIR_RIGHT, 1'b0, 64'h9);
        tick();
        chk("piso_load", aq[0], 64'h9);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, SH_SHIFT, DIR_RIGHT, 1'b0, 64'd0);
            #1 chk($sformatf("piso_sout%0d", k), {63'd0, asout[0]}, {63'd0, piso_sout[k]});
            tick();
        end
        chk("piso_empty", aq[0], 64'h0);
        chk("piso_fd", {63'd0, afd[0]}, 64'h1);

        // Rotate left, two frames.
        drive(0, 1'b1, SH_LOAD, DIR_RIGHT, 1'b0, 64'h8);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b1, SH_ROT, DIR_LEFT, ~k[0], 64'd0);
            tick();
            chk($sformatf("rot_q%0d", k), aq[0], {60'd0, rot_q[k % 4]});
            chk($sformatf("rot_fd%0d", k), {63'd0, afd[0]}, {63'd0, (k % 4 == 3)});
        end

        // Enable gating.
        drive(0, 1'b1, SH_LOAD, DIR_LEFT, 1'b0, 64'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, SH_SHIFT, DIR_LEFT, 1'b1, 64'd0);
            tick();
        end
        chk("en_cnt2", acnt[0], 64'h2);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, SH_SHIFT, DIR_LEFT, 1'b1, 64'd0);
            tick();
            chk($sformatf("en_off_q%0d", k), aq[0], 64'h3);
            chk($sformatf("en_off_cnt%0d", k), acnt[0], 64'h2);
            chk($sformatf("en_off_fd%0d", k), {63'd0, afd[0]}, 64'h0);
        end
        drive(0, 1'b1, SH_SHIFT, DIR_LEFT, 1'b1, 64'd0);
        tick();
        chk("en_q3", aq[0], 64'h7);
        chk("en_fd3", {63'd0, afd[0]}, 64'h0);
        tick();
        chk("en_q4", aq[0], 64'hf);
        chk("en_fd4", {63'd0, afd[0]}, 64'h1);

        // Load collision, WIDTH=4.
        drive(0, 1'b1, SH_LOAD, DIR_RIGHT, 1'b0, 64'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, SH_SHIFT, DIR_RIGHT, 1'b0, 64'd0);
            tick();
        end
        chk("coll4_cnt3", acnt[0], 64'h3);
        drive(0, 1'b1, SH_LOAD, DIR_RIGHT, 1'b0, 64'h6);
        tick();
        chk("coll4_q", aq[0], 64'h6);
        chk("coll4_cnt", acnt[0], 64'h0);
        chk("coll4_fd", {63'd0, afd[0]}, 64'h0);
        drive(0, 1'b0, SH_HOLD, DIR_RIGHT, 1'b0, 64'd0);

        // Load collision and wrap, WIDTH=5.
        drive(1, 1'b1, SH_LOAD, DIR_RIGHT, 1'b0, 64'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, SH_SHIFT, DIR_RIGHT, 1'b1, 64'd0);
            tick();
        end
        chk("coll5_q", aq[1], 64'h1e);
        chk("coll5_cnt4", acnt[1], 64'h4);
        drive(1, 1'b1, SH_LOAD, DIR_RIGHT, 1'b0, 64'h0d);
        tick();
        chk("coll5_load_q", aq[1], 64'h0d);
        chk("coll5_load_cnt", acnt[1], 64'h0);
        chk("coll5_load_fd", {63'd0, afd[1]}, 64'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1'b1, SH_SHIFT, DIR_LEFT, 1'b0, 64'd0);
            tick();
            chk($sformatf("wrap5_fd%0d", k), {63'd0, afd[1]}, {63'd0, (k == 4)});
        end
        drive(1, 1'b0, SH_HOLD, DIR_RIGHT, 1'b0, 64'd0);

        // Reset in the middle of a frame.
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, SH_SHIFT, DIR_RIGHT, 1'b1, 64'd0);
            tick();
        end
        #1 rst = 1'b0;
        mreset(0); mreset(1);
        #1;
        chk("midrst_q", aq[0], 64'h0);
        chk("midrst_sout", {63'd0, asout[0]}, 64'h0);
        chk("midrst_cnt", acnt[0], 64'h0);
        chk("midrst_fd", {63'd0, afd[0]}, 64'h0);
        chk("midrst_q5", aq[1], 64'h16);
        tick();
        rst = 1'b1;

        // Random traffic on both widths.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++)
                drive(i, ($urandom_range(0, 9) != 0), shift_mode_e'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                mreset(0); mreset(1);
                tick();
                rst = 1'b1;
            end
            tick();
        end

        @(posedge clk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised successor to the team's 4-bit SISO D-flip-flop shift register. It supports SISO, SIPO, PISO and PIPO use through a mode select, with selectable shift direction, rotate, and clock enable. A shift counter raises a one-cycle frame_done strobe after every WIDTH shifts. It serves as the common serialiser/deserialiser building block for the sequential register library.

Parameters:
WIDTH, 4, register width in bits; legal range 2..64.
RST_VAL, '0, value loaded into q on reset; WIDTH bits.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
en  input  1  clock enable; 0 freezes all state.
mode  input  2  operation select: 00 hold, 01 shift, 10 parallel load, 11 rotate.
dir  input  1  0 = shift/rotate right (toward LSB); 1 = shift/rotate left (toward MSB).
sin  input  1  serial data in.
pin  input  WIDTH  parallel data in.
q  output  WIDTH  register contents; this is the parallel output.
sout  output  1  serial data out.
bit_cnt  output  $clog2(WIDTH)  shifts completed since the last load, wrap or reset.
frame_done  output  1  one-cycle strobe that marks the WIDTH-th shift.

Behaviour:
- Reset (rst=0), asynchronous and applied at any time, including mid-frame: q=RST_VAL, bit_cnt=0, frame_done=0. Release is synchronous to the next clk edge.
- All state updates on the clk rising edge, only when en=1. With en=0: q and bit_cnt hold, and frame_done=0 from the next edge.
- mode 00, hold: q and bit_cnt unchanged, frame_done=0.
- mode 01, shift:
  - dir=0: q <= {sin, q[WIDTH-1:1]}.
  - dir=1: q <= {q[WIDTH-2:0], sin}.
- mode 11, rotate: same as shift, but the bit shifted out replaces sin. sin is ignored.
- mode 10, load: q <= pin, bit_cnt <= 0, frame_done <= 0. Load has priority over counting; a load at bit_cnt=WIDTH-1 produces no strobe.
- sout is combinational from q, with no extra latency: q[0] when dir=0, q[WIDTH-1] when dir=1.
- Counter, for modes 01 and 11 with en=1:
  - If bit_cnt==WIDTH-1: bit_cnt <= 0 and frame_done <= 1. The strobe is registered and visible in the cycle after the WIDTH-th shift edge.
  - Otherwise: bit_cnt <= bit_cnt+1 and frame_done <= 0.
  - Wrap-around is continuous; back-to-back frames give a strobe every WIDTH shifts.
- When WIDTH is not a power of two, the counter still wraps at WIDTH-1.
- Changing dir mid-frame is legal. It does not reset bit_cnt.
- Undefined mode values cannot occur, since all 4 encodings are defined.

Decomposition:
- Package shift_pkg holds:
  - enum shift_mode_e {SH_HOLD=2'b00, SH_SHIFT=2'b01, SH_LOAD=2'b10, SH_ROT=2'b11}
  - DIR_RIGHT=1'b0 and DIR_LEFT=1'b1 constants.
- One natural sub-module: shift_bit_counter. It is parametrised by WIDTH, has inputs clk, rst, inc and clr, and outputs bit_cnt and frame_done. It holds the wrap and strobe logic.
- The data path stays in universal_shift_reg.

Test Plan:
1. Reset, WIDTH=4, RST_VAL=0: drive rst=0 mid-operation -> q=0000, sout=0, bit_cnt=0, frame_done=0 immediately, without waiting for a clk edge.
2. SISO right shift, mode=01, dir=0, sin=1,0,1,1 over 4 edges -> q=1000, 0100, 1010, 1101. frame_done=1 for exactly the one cycle after the 4th edge, and bit_cnt returns to 0.
3. PISO: load pin=1001, then shift right with sin=0 -> sout=1,0,0,1 on successive cycles, and q ends at 0000 after 4 shifts.
4. Rotate left, mode=11, dir=1, from q=1000 -> q=0001, 0010, 0100, 1000, with a frame_done strobe after the 4th edge. 8 rotates give 2 strobes 4 cycles apart.
5. Enable gating: shift 2 bits (bit_cnt=2), hold en=0 for 3 cycles, then shift 2 more -> q and bit_cnt frozen during en=0, and frame_done fires only after the 4th enabled shift.
6. Load collision: with bit_cnt=3, apply mode=10 and pin=0110 -> q=0110, bit_cnt=0, no frame_done. Repeat with WIDTH=5 to confirm wrap at 4 and a 3-bit bit_cnt.
